led_fader: RTL
==============

// Module: led_fader
// PURPOSE
//  Downstream stage of the memory-mapped LED register: consumes its N-bit LED vector and drives the board LEDs.
//  Each LED gets PWM brightness that ramps linearly toward full-on or full-off whenever its request bit changes.
//  Purely local timing, no bus interface; sits between the LED register and the FPGA output pins.
// PARAMETERS
//  N          4     number of LED channels
//  PWM_BITS   8     PWM counter / brightness level width
//  FADE_DIV   1024  clk cycles per fade tick (>=2); full ramp = (2**PWM_BITS-1)*FADE_DIV cycles
// PORTS
//  clk       in   1         system clock
//  rst       in   1         synchronous, active-high reset
//  led_in    in   N         LED request vector from the LED register (1 = on)
//  fade_en   in   1         1 = ramp levels; 0 = levels jump immediately to target
//  led_out   out  N         PWM-modulated LED pin drive (registered)
//  level     out  N*PWM_BITS  current brightness, channel i at [i*PWM_BITS +: PWM_BITS] (debug/status)
// BEHAVIOUR
//  Reset: led_out=0, all levels=0, pwm_cnt=0, prescaler=0. Reset is synchronous and dominates all other inputs.
//  Reset mid-ramp: the level is forced to 0 on the next edge, with no residual ramp.
//  MAX = 2**PWM_BITS-1.
//  Prescaler: 0..FADE_DIV-1, wraps to 0. tick=1 for exactly one cycle when the prescaler equals FADE_DIV-1.
//  pwm_cnt: free-running PWM_BITS counter, +1 every clk, wraps MAX->0.
//  Per channel, state derived from (led_in[i], level[i]):
//   OFF    : level==0 && !led_in    -> hold
//   RISING : led_in && level<MAX    -> on tick, level+1
//   ON     : level==MAX && led_in   -> hold
//   FALLING: !led_in && level>0     -> on tick, level-1
//  Level saturates at 0 and MAX; no wrap.
//  Request reversal mid-ramp: the next tick changes direction from the current level; no jump.
//  fade_en=0: level<=led_in?MAX:0 on the next clk edge, regardless of tick.
//  fade_en re-asserted: ramping resumes from the current level.
//  led_in is sampled every clk. Changes shorter than one tick only affect the level if present on a tick cycle.
//  PWM compare: dutyn = (level==MAX) ? 1 : (pwm_cnt < level). led_out[i] <= dutyn, one-cycle registered latency.
//   level==0 gives a constant 0. level==MAX gives a constant 1, with no glitch at the pwm_cnt wrap.
//   Otherwise the high time is exactly level cycles per 2**PWM_BITS-cycle period.
//  All channels share pwm_cnt and tick, so they are phase-aligned. Channels are otherwise independent.
// STRUCTURE
//  Shared package (led_pkg):
//   - typedef enum {OFF,RISING,ON,FALLING} fade_state_e, used for debug decode and assertions.
//   - function sat_step(level, up) returning the saturated +/-1.
//  Top (led_fader): owns the prescaler and pwm_cnt; generate loop instantiates N sub-modules.
//  Sub-module led_fade_chan: one channel's level register, saturating step, compare and led_out flop.
//   Inputs: clk, rst, req, fade_en, tick, pwm_cnt.
// TESTING (bench: N=4, PWM_BITS=4, FADE_DIV=4, MAX=15)
//  1. Release reset, led_in=0, fade_en=1, run 200 cycles -> led_out==0, all levels==0 throughout.
//  2. led_in=4'b0001 at cycle 0.
//     -> level[0] increments on every tick and reaches 15 after 15 ticks (<=60 cycles).
//     -> afterwards led_out[0] is constant 1; channels 1-3 stay 0.
//  3. Hold level[0]=8, check 64 cycles -> led_out[0] is high exactly 8 of every 16 cycles, one cycle after pwm_cnt<8.
//  4. Reversal: at level[0]=10 drop led_in[0].
//     -> the next tick gives 9, then decrements to 0 and saturates; led_out[0] then stays 0.
//  5. fade_en=0, led_in=4'b1010 -> next edge level[1]=level[3]=15, level[0]=level[2]=0; outputs follow in 1 cycle.
//  6. Assert rst for 1 cycle while ch2 is at level 7 and rising.
//     -> next edge: all levels 0, led_out 0, prescaler 0.
//     -> the ramp restarts from 0 with the first tick after FADE_DIV cycles.

Source files
------------

// File: rtl/led_fader_pkg.sv
// Shared types and helpers for the LED fader: channel state decode and the saturating level step.
package led_pkg;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    RISING  = 2'd1,
    ON      = 2'd2,
    FALLING = 2'd3
  } fade_state_e;

  // One brightness step toward max (up=1) or toward 0 (up=0), clamped at both ends.
  function automatic int unsigned sat_step(input int unsigned level,
                                           input int unsigned max,
                                           input logic        up);
    if (up) begin
      return (level >= max) ? max : level + 1;
    end
    return (level == 0) ? 0 : level - 1;
  endfunction

endpackage

// File: rtl/led_fader_if.sv
// LED request vector in, PWM pin drive and per-channel brightness out.
interface led_fader_if #(
  parameter int N        = 4,
  parameter int PWM_BITS = 8
);
  logic [N-1:0]          led_in;
  logic                  fade_en;
  logic [N-1:0]          led_out;
  logic [N*PWM_BITS-1:0] level;

  modport master (output led_in, output fade_en, input led_out, input level);
  modport slave  (input led_in, input fade_en, output led_out, output level);
endinterface

// File: rtl/led_fade_chan.sv
// One LED channel: brightness level register with saturating ramp, PWM compare and registered pin drive.
module led_fade_chan
  import led_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                fade_en,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic [PWM_BITS-1:0] level,
  output logic                led_out
);

  localparam logic [PWM_BITS-1:0] MAX = '1;

  fade_state_e         state;
  logic [PWM_BITS-1:0] step_lvl;
  logic                duty_p0;

  always_comb begin
    state = OFF;
    if (req) begin
      state = (level == MAX) ? ON : RISING;
    end else begin
      state = (level == '0) ? OFF : FALLING;
    end
    step_lvl = PWM_BITS'(sat_step(32'(level), 32'(MAX), state == RISING));
    // Full brightness is forced high so the pin never blips low at the pwm_cnt wrap.
    duty_p0  = (level == MAX) || (pwm_cnt < level);
  end

  // Stage p0 -> p1: level update and registered pin drive
  always_ff @(posedge clk) begin
    if (rst) begin
      level   <= '0;
      led_out <= 1'b0;
    end else begin
      led_out <= duty_p0;
      if (!fade_en) begin
        level <= req ? MAX : '0;
      end else if (tick && (state == RISING || state == FALLING)) begin
        level <= step_lvl;
      end
    end
  end

endmodule

// File: rtl/led_fader.sv
// LED fader top: shared fade prescaler and PWM counter, one led_fade_chan per LED so all channels stay phase-aligned.
module led_fader
  import led_pkg::*;
#(
  parameter int N        = 4,
  parameter int PWM_BITS = 8,
  parameter int FADE_DIV = 1024
) (
  input  logic        clk,
  input  logic        rst,
  led_fader_if.slave  bus
);

  localparam int PW = (FADE_DIV > 2) ? $clog2(FADE_DIV) : 1;

  logic [PW-1:0]         presc;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic                  tick;
  logic [N-1:0]          out_w;
  logic [N*PWM_BITS-1:0] lvl_w;

  assign tick = (presc == PW'(FADE_DIV - 1));

  // Stage p0: shared timebase
  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      presc   <= tick ? '0 : presc + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    led_fade_chan #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .req     (bus.led_in[i]),
      .fade_en (bus.fade_en),
      .tick    (tick),
      .pwm_cnt (pwm_cnt),
      .level   (lvl_w[i*PWM_BITS +: PWM_BITS]),
      .led_out (out_w[i])
    );
  end

  assign bus.led_out = out_w;
  assign bus.level   = lvl_w;

endmodule
